// File: rtl/adc_sample_capture_if.sv
// Signal bundle between the serial ADC front end and its surroundings:
// enable control, the 4-wire ADC pins and the captured sample stream.
interface adc_sample_capture_if;
    logic        ENABLE;
    logic        ADC_CONVST;
    logic        ADC_SCK;
    logic        ADC_SDI;
    logic        ADC_SDO;
    logic [11:0] VALUE;
    logic        SAMPLE_TR;
    logic        OVERRUN;

    modport master (
        input  ENABLE, ADC_SDO,
        output ADC_CONVST, ADC_SCK, ADC_SDI, VALUE, SAMPLE_TR, OVERRUN
    );

    modport slave (
        output ENABLE, ADC_SDO,
        input  ADC_CONVST, ADC_SCK, ADC_SDI, VALUE, SAMPLE_TR, OVERRUN
    );
endinterface

// File: rtl/adc_sample_capture.sv
// Serial ADC front end: on each sample tick runs one conversion + 12-bit readout,
// publishes the result on VALUE and strobes SAMPLE_TR one edge later.
module adc_sample_capture #(
    parameter int         CLK_DIV     = 2,
    parameter int         CONV_CYCLES = 80,
    parameter int         SAMPLE_DIV  = 1134,
    parameter logic [2:0] CHANNEL     = 3'd0
) (
    input  logic               CLK,
    input  logic               RESET,
    adc_sample_capture_if.master bus
);
    localparam int TICK_W = $clog2(SAMPLE_DIV + 1);
    localparam int PH_W   = $clog2(CONV_CYCLES + 2 * CLK_DIV + 1);
    localparam int HALF   = SAMPLE_DIV / 2;

    // Config word followed by six zero bits, one bit per SCK period.
    localparam logic [11:0] SDI_WORD = {1'b1, CHANNEL[0], CHANNEL[2], CHANNEL[1],
                                        1'b1, 1'b0, 6'b000000};

    typedef enum logic [2:0] {IDLE, CONV, GAP, SHIFT, DONE} state_t;

    state_t              state;
    logic [TICK_W-1:0]   tick_cnt;
    logic [PH_W-1:0]     ph_cnt;
    logic [3:0]          bit_idx;
    logic [11:0]         shreg;
    logic [11:0]         value;
    logic                convst;
    logic                sck;
    logic                sdi;
    logic                overrun;
    logic                done_p0;
    logic                sample_tr;
    logic [TICK_W-1:0]   tr_cnt;
    logic                tick;

    function automatic logic sdi_bit(input logic [3:0] period);
        return SDI_WORD[4'd11 - period];
    endfunction

    assign tick = bus.ENABLE && (tick_cnt == TICK_W'(SAMPLE_DIV - 1));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tick_cnt <= '0;
        end else if (!bus.ENABLE || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            ph_cnt  <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            value   <= 12'h800;
            convst  <= 1'b0;
            sck     <= 1'b0;
            sdi     <= 1'b0;
            overrun <= 1'b0;
            done_p0 <= 1'b0;
        end else begin
            done_p0 <= 1'b0;
            // Ticks that land on a busy transaction are dropped, but remembered.
            if (tick && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (tick) begin
                        state  <= CONV;
                        convst <= 1'b1;
                        ph_cnt <= '0;
                    end
                end
                CONV: begin
                    if (ph_cnt == PH_W'(CONV_CYCLES - 1)) begin
                        state  <= GAP;
                        convst <= 1'b0;
                        sdi    <= sdi_bit(4'd0);
                        ph_cnt <= '0;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                GAP: begin
                    state   <= SHIFT;
                    ph_cnt  <= '0;
                    bit_idx <= '0;
                end
                SHIFT: begin
                    // SDO is captured on the same edge that raises SCK.
                    if (ph_cnt == PH_W'(CLK_DIV - 1)) begin
                        sck   <= 1'b1;
                        shreg <= {shreg[10:0], bus.ADC_SDO};
                    end
                    if (ph_cnt == PH_W'(2 * CLK_DIV - 1)) begin
                        sck    <= 1'b0;
                        ph_cnt <= '0;
                        if (bit_idx == 4'd11) begin
                            state <= DONE;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                            sdi     <= sdi_bit(bit_idx + 4'd1);
                        end
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                DONE: begin
                    value   <= shreg;
                    done_p0 <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobe stage: rises one edge after VALUE, lasts half a sample period.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sample_tr <= 1'b0;
            tr_cnt    <= '0;
        end else if (done_p0) begin
            sample_tr <= 1'b1;
            tr_cnt    <= TICK_W'(HALF - 1);
        end else if (tr_cnt != '0) begin
            tr_cnt <= tr_cnt - 1'b1;
        end else begin
            sample_tr <= 1'b0;
        end
    end

    assign bus.ADC_CONVST = convst;
    assign bus.ADC_SCK    = sck;
    assign bus.ADC_SDI    = sdi;
    assign bus.VALUE      = value;
    assign bus.SAMPLE_TR  = sample_tr;
    assign bus.OVERRUN    = overrun;
endmodule

// File: tb/tb_adc_sample_capture.sv
// Directed + randomized bench for adc_sample_capture with a behavioural ADC model.
module tb_adc_sample_capture;
    localparam logic [2:0] CH = 3'd5;
    localparam int CONV = 80;
    localparam int CDIV = 2;
    localparam int SDIV = 1134;
    localparam int VAL_LAT = CONV + 24 * CDIV + 2;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    adc_sample_capture_if ifa ();
    adc_sample_capture_if ifb ();

    adc_sample_capture #(.CLK_DIV(CDIV), .CONV_CYCLES(CONV), .SAMPLE_DIV(SDIV), .CHANNEL(CH))
        dut (.CLK(CLK), .RESET(RESET), .bus(ifa.master));

    adc_sample_capture #(.CLK_DIV(CDIV), .CONV_CYCLES(CONV), .SAMPLE_DIV(100), .CHANNEL(3'd0))
        dut_ovr (.CLK(CLK), .RESET(RESET), .bus(ifb.master));

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ADC model: picks a word at conversion start, shifts it out MSB first,
    // advancing one bit on every SCK fall after CONVST drops.
    logic [11:0] adc_q[$];
    logic [11:0] cur_word = 12'h000;
    int sck_falls = 0;
    int fall_snap = 0;

    function automatic logic [3:0] adc_idx(input int falls);
        return (falls >= 11) ? 4'd0 : 4'(11 - falls);
    endfunction

    always @(posedge ifa.ADC_CONVST) begin
        if (adc_q.size() > 0) cur_word = adc_q.pop_front();
        else cur_word = 12'($urandom);
    end
    always @(negedge ifa.ADC_SCK) sck_falls++;
    always @(negedge ifa.ADC_CONVST) fall_snap = sck_falls;
    assign ifa.ADC_SDO = cur_word[adc_idx(sck_falls - fall_snap)];
    assign ifb.ADC_SDO = 1'b1;

    // Monitors for DUT A
    int a_conv_rises = 0, conv_rise_cyc = 0, conv_hi = 0;
    int sck_rises_total = 0, sck_snap = 0;
    int value_chg_cyc = 0, tr_rise_cyc = 0, tr_rises = 0, tr_hi = 0;
    logic [11:0] sdi_bits = '0;
    logic [11:0] val_d;
    logic conv_d = 1'b0, tr_d = 1'b0;

    always @(posedge ifa.ADC_SCK) begin
        sdi_bits = {sdi_bits[10:0], ifa.ADC_SDI};
        sck_rises_total++;
    end

    always @(negedge CLK) begin
        if (ifa.ADC_CONVST && !conv_d) begin
            a_conv_rises++;
            conv_rise_cyc = cyc;
            conv_hi = 0;
            sck_snap = sck_rises_total;
        end
        if (ifa.ADC_CONVST) conv_hi++;
        if (ifa.VALUE !== val_d) value_chg_cyc = cyc;
        if (ifa.SAMPLE_TR && !tr_d) begin
            tr_rises++;
            tr_rise_cyc = cyc;
            tr_hi = 0;
        end
        if (ifa.SAMPLE_TR) tr_hi++;
        conv_d = ifa.ADC_CONVST;
        tr_d = ifa.SAMPLE_TR;
        val_d = ifa.VALUE;
    end

    // Monitor for DUT B
    int b_rise_q[$];
    logic b_conv_d = 1'b0;
    always @(negedge CLK) begin
        if (ifb.ADC_CONVST && !b_conv_d) b_rise_q.push_back(cyc);
        b_conv_d = ifb.ADC_CONVST;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    logic [11:0] exp_words[7];
    logic [11:0] cfg_exp;
    int n, tgt, t1, prev_chg;

    initial begin
        exp_words[0] = 12'hA5C;
        exp_words[1] = 12'h000;
        exp_words[2] = 12'hFFF;
        exp_words[3] = 12'h800;
        for (int i = 4; i < 7; i++) begin
            do exp_words[i] = 12'($urandom); while (exp_words[i] == exp_words[i-1]);
        end
        cfg_exp = {1'b1, CH[0], CH[2], CH[1], 1'b1, 1'b0, 6'b000000};

        RESET = 1'b1;
        ifa.ENABLE = 1'b0;
        ifb.ENABLE = 1'b0;
        repeat (3) step();
        chk("rst_value", 32'(ifa.VALUE), 32'h800);
        chk("rst_convst", 32'(ifa.ADC_CONVST), 0);
        chk("rst_sck", 32'(ifa.ADC_SCK), 0);
        chk("rst_sdi", 32'(ifa.ADC_SDI), 0);
        chk("rst_tr", 32'(ifa.SAMPLE_TR), 0);
        chk("rst_overrun", 32'(ifa.OVERRUN), 0);
        RESET = 1'b0;

        repeat (2000) step();
        chk("idle_value", 32'(ifa.VALUE), 32'h800);
        chk("idle_tr", 32'(ifa.SAMPLE_TR), 0);
        chk("idle_convst", 32'(ifa.ADC_CONVST), 0);
        chk("idle_sck", 32'(ifa.ADC_SCK), 0);
        chk("idle_overrun", 32'(ifa.OVERRUN), 0);
        chk("idle_sck_edges", 32'(sck_rises_total), 0);
        chk("idle_b_txn", 32'(b_rise_q.size()), 0);

        // Overrun: 130-cycle transactions with a 100-cycle tick.
        ifb.ENABLE = 1'b1;
        n = 0;
        while (b_rise_q.size() < 1 && n < 300) begin step(); n++; end
        chk("ovr_first_txn", 32'(b_rise_q.size() >= 1), 1);
        t1 = (b_rise_q.size() > 0) ? b_rise_q[0] : cyc;
        chk("ovr_before", 32'(ifb.OVERRUN), 0);
        while (cyc < t1 + 98) step();
        chk("ovr_pre_tick2", 32'(ifb.OVERRUN), 0);
        while (cyc < t1 + 101) step();
        chk("ovr_after_tick2", 32'(ifb.OVERRUN), 1);
        n = 0;
        while (b_rise_q.size() < 2 && n < 300) begin step(); n++; end
        chk("ovr_second_txn", 32'(b_rise_q.size() >= 2), 1);
        if (b_rise_q.size() >= 2) chk("ovr_dropped_gap", 32'(b_rise_q[1] - b_rise_q[0]), 200);
        chk("ovr_value", 32'(ifb.VALUE), 32'hFFF);
        ifb.ENABLE = 1'b0;
        repeat (300) step();
        chk("ovr_sticky", 32'(ifb.OVERRUN), 1);

        // Main capture on DUT A
        for (int i = 0; i < 7; i++) adc_q.push_back(exp_words[i]);
        ifa.ENABLE = 1'b1;
        n = 0;
        while (a_conv_rises < 1 && n < 1300) begin step(); n++; end
        chk("txn0_start", 32'(a_conv_rises), 1);
        n = 0;
        while (ifa.ADC_CONVST && n < 200) begin step(); n++; end
        chk("txn0_convst_len", 32'(conv_hi), CONV);
        n = 0;
        while (tr_rises < 1 && n < 200) begin step(); n++; end
        chk("txn0_tr_seen", 32'(tr_rises), 1);
        chk("txn0_value", 32'(ifa.VALUE), 32'(exp_words[0]));
        chk("txn0_value_lat", 32'(value_chg_cyc - conv_rise_cyc), VAL_LAT);
        chk("txn0_tr_lat", 32'(tr_rise_cyc - conv_rise_cyc), VAL_LAT + 1);
        chk("txn0_sck_rises", 32'(sck_rises_total - sck_snap), 12);
        chk("txn0_sdi_bits", 32'(sdi_bits), 32'(cfg_exp));
        n = 0;
        while (ifa.SAMPLE_TR && n < 700) begin step(); n++; end
        chk("txn0_tr_len", 32'(tr_hi), SDIV / 2);
        prev_chg = value_chg_cyc;

        for (int i = 1; i < 7; i++) begin
            n = 0;
            while (tr_rises < i + 1 && n < 1300) begin step(); n++; end
            chk("txn_tr_seen", 32'(tr_rises), 32'(i + 1));
            chk("txn_value", 32'(ifa.VALUE), 32'(exp_words[i]));
            chk("txn_spacing", 32'(value_chg_cyc - prev_chg), SDIV);
            chk("txn_tr_after_value", 32'(tr_rise_cyc - value_chg_cyc), 1);
            chk("txn_sck_rises", 32'(sck_rises_total - sck_snap), 12);
            prev_chg = value_chg_cyc;
        end
        chk("main_no_overrun", 32'(ifa.OVERRUN), 0);
        chk("ovr_sticky_late", 32'(ifb.OVERRUN), 1);

        // Reset during SHIFT, in bit period 6
        tgt = a_conv_rises + 1;
        n = 0;
        while (a_conv_rises < tgt && n < 1300) begin step(); n++; end
        chk("abort_txn_start", 32'(a_conv_rises), 32'(tgt));
        n = 0;
        while ((sck_rises_total - sck_snap) < 7 && n < 200) begin step(); n++; end
        chk("abort_in_bit6", 32'(sck_rises_total - sck_snap), 7);
        RESET = 1'b1;
        #1;
        chk("abort_sck", 32'(ifa.ADC_SCK), 0);
        chk("abort_convst", 32'(ifa.ADC_CONVST), 0);
        chk("abort_tr", 32'(ifa.SAMPLE_TR), 0);
        chk("abort_value", 32'(ifa.VALUE), 32'h800);
        chk("abort_overrun_cleared", 32'(ifb.OVERRUN), 0);
        adc_q.push_back(12'h3C7);
        repeat (3) step();
        RESET = 1'b0;
        tgt = tr_rises + 1;
        n = 0;
        while (tr_rises < tgt && n < 1500) begin step(); n++; end
        chk("recover_tr_seen", 32'(tr_rises), 32'(tgt));
        chk("recover_value", 32'(ifa.VALUE), 32'h3C7);
        chk("recover_value_lat", 32'(value_chg_cyc - conv_rise_cyc), VAL_LAT);
        chk("recover_sck_rises", 32'(sck_rises_total - sck_snap), 12);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
